// File: rtl/lsu_pkg.sv
// Package for the parametrised MEM stage / load-store unit.
// Contents:
//   state_t        split FSM states (IDLE, SPLIT)
//   src_t          source of the data returned for a load
//   F3_*           load/store width encodings from funct3
//   *_DEF          default address map and sizes
//   lsu_size_mask  byte mask of an access width, anchored at lane 0
//   lsu_extend     sign/zero extension of a right-justified load value
package lsu_pkg;

  typedef enum logic [0:0] {IDLE, SPLIT} state_t;

  typedef enum logic [1:0] {SrcNone, SrcDmem, SrcReg} src_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned DMEM_WORDS_DEF = 16384;
  localparam int unsigned NUM_GPO_DEF    = 5;
  localparam logic [31:0] GPO_BASE_DEF   = 32'h1000_0000;
  localparam logic [31:0] GPI_BASE_DEF   = 32'h1001_0000;

  function automatic logic [3:0] lsu_size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lsu_extend(input logic [31:0] raw, input logic [2:0] f3);
    case (f3)
      F3_B:    return {{24{raw[7]}}, raw[7:0]};
      F3_H:    return {{16{raw[15]}}, raw[15:0]};
      F3_W:    return raw;
      F3_BU:   return {24'd0, raw[7:0]};
      F3_HU:   return {16'd0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Pipeline <-> MEM stage access bus.
//   master (pipeline): valid, kill, read, write, funct3, addr, wdata out;
//                      stall, rvalid, rdata, misalign in
//   slave  (MEM stage): the reverse
interface lsu_mem_stage_if;
  logic        valid;
  logic        kill;
  logic        read;
  logic        write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        rvalid;
  logic [31:0] rdata;
  logic        misalign;

  modport master (
    output valid, kill, read, write, funct3, addr, wdata,
    input  stall, rvalid, rdata, misalign
  );

  modport slave (
    input  valid, kill, read, write, funct3, addr, wdata,
    output stall, rvalid, rdata, misalign
  );
endinterface

// File: rtl/lsu_bram.sv
// Data memory: DMEM_WORDS x 32 bit, four byte enables, synchronous read.
// o_q shows mem[i_addr] one cycle after the address; a write to the same word
// in that cycle is not visible yet (read-before-write).
// Ports: i_clk, i_we, i_be[3:0], i_addr[AW-1:0], i_wdata[31:0], o_q[31:0].
module lsu_bram #(
  parameter int unsigned DMEM_WORDS = 16384,
  parameter int unsigned AW         = $clog2(DMEM_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_q
);
  logic [31:0] mem [DMEM_WORDS];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    o_q <= mem[i_addr];
  end
endmodule

// File: rtl/lsu_mem_stage.sv
// MEM stage / load-store unit: DMEM, NUM_GPO output registers, one synchronised
// input port. Loads return extended data one cycle after issue (two when split).
// Optional feature macro: LSU_MISALIGN_SPLIT_EN
//   defined:   misaligned DMEM H/W accesses take two cycles (IDLE->SPLIT), one stall
//   undefined: misaligned DMEM accesses are dropped and raise a one-cycle misalign pulse
// Ports: i_clk, i_reset (sync, active-low), bus (lsu_mem_stage_if.slave),
//        i_gpi (async inputs), o_gpo (channel k at [32k+31:32k]).
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_WORDS = DMEM_WORDS_DEF,
  parameter int unsigned NUM_GPO    = NUM_GPO_DEF,
  parameter logic [31:0] GPO_BASE   = GPO_BASE_DEF,
  parameter logic [31:0] GPI_BASE   = GPI_BASE_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  lsu_mem_stage_if.slave       bus,
  input  logic [31:0]          i_gpi,
  output logic [32*NUM_GPO-1:0] o_gpo
);
  localparam int unsigned AW = $clog2(DMEM_WORDS);

  logic          accept, is_dmem, is_gpo, is_gpi, is_half, is_word, mis_hit, mis_drop;
  logic          in_split, dmem_we;
  logic [19:0]   gpo_off;
  logic [31:0]   gpo_rd, dmem_q, raw, sh;
  logic [63:0]   r64, data64;
  logic [7:0]    be8;
  logic [2:0]    p_f3;
  logic [1:0]    p_off, g_off;
  logic [31:0]   p_wdata, g_data;
  logic [3:0]    g_be;
  logic [AW-1:0] dmem_addr;

  logic          rvalid_q, rd_split_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  src_t          src_q;
  logic [31:0]   io_q, buf_q, gpi_s1_q, gpi_s2_q;
  logic [31:0]   gpo_q [NUM_GPO];
`ifdef LSU_MISALIGN_SPLIT_EN
  state_t        state_q;
  logic [AW-1:0] word1_q;
  logic [31:0]   wdata_q;
  logic          read_q, write_q;
`else
  logic          misalign_q;
`endif

  // Decode of the access currently presented by the pipeline.
  assign accept  = bus.valid & ~bus.kill & (bus.read | bus.write);
  assign is_dmem = (bus.addr >> (AW + 2)) == 32'd0;
  assign gpo_off = bus.addr[31:12] - GPO_BASE[31:12];
  assign is_gpo  = ~is_dmem & ({12'd0, gpo_off} < NUM_GPO);
  assign is_gpi  = ~is_dmem & ~is_gpo & (bus.addr[31:16] == GPI_BASE[31:16]);
  assign is_half = bus.funct3[1:0] == 2'b01;
  assign is_word = bus.funct3[1:0] == 2'b10;
  assign mis_hit = is_dmem & ((is_half & bus.addr[0]) | (is_word & (bus.addr[1:0] != 2'b00)));

`ifdef LSU_MISALIGN_SPLIT_EN
  assign in_split  = (state_q == SPLIT);
  assign mis_drop  = 1'b0;
  assign p_f3      = in_split ? f3_q : bus.funct3;
  assign p_off     = in_split ? off_q : bus.addr[1:0];
  assign p_wdata   = in_split ? wdata_q : bus.wdata;
  assign dmem_addr = in_split ? word1_q : bus.addr[AW+1:2];
  assign dmem_we   = i_reset & (in_split ? write_q : (accept & bus.write & is_dmem));
  assign bus.stall = ~in_split & accept & mis_hit;
  assign bus.misalign = 1'b0;
`else
  assign in_split  = 1'b0;
  assign mis_drop  = mis_hit;
  assign p_f3      = bus.funct3;
  assign p_off     = bus.addr[1:0];
  assign p_wdata   = bus.wdata;
  assign dmem_addr = bus.addr[AW+1:2];
  assign dmem_we   = i_reset & accept & bus.write & is_dmem & ~mis_hit;
  assign bus.stall = 1'b0;
  assign bus.misalign = misalign_q;
`endif

  // Lanes of an access spanning two words: low half goes to word0, high half to word1.
  assign be8    = {4'b0000, lsu_size_mask(p_f3)} << p_off;
  assign data64 = {32'd0, p_wdata} << {p_off, 3'b000};

  // GPO registers are word-aligned: halves snap to lanes 0/2, words to lane 0.
  assign g_off  = is_word ? 2'b00 : (is_half ? {bus.addr[1], 1'b0} : bus.addr[1:0]);
  assign g_be   = lsu_size_mask(bus.funct3) << g_off;
  assign g_data = bus.wdata << {g_off, 3'b000};

  lsu_bram #(
    .DMEM_WORDS (DMEM_WORDS),
    .AW         (AW)
  ) u_bram (
    .i_clk   (i_clk),
    .i_we    (dmem_we),
    .i_be    (in_split ? be8[7:4] : be8[3:0]),
    .i_addr  (dmem_addr),
    .i_wdata (in_split ? data64[63:32] : data64[31:0]),
    .o_q     (dmem_q)
  );

  always_comb begin
    gpo_rd = '0;
    o_gpo  = '0;
    for (int k = 0; k < NUM_GPO; k++) begin
      if (gpo_off == 20'(k)) gpo_rd = gpo_q[k];
      o_gpo[32*k +: 32] = gpo_q[k];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      rvalid_q   <= 1'b0;
      rd_split_q <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      src_q      <= SrcNone;
      io_q       <= '0;
      buf_q      <= '0;
      gpi_s1_q   <= '0;
      gpi_s2_q   <= '0;
      for (int k = 0; k < NUM_GPO; k++) gpo_q[k] <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      state_q    <= IDLE;
      word1_q    <= '0;
      wdata_q    <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
`else
      misalign_q <= 1'b0;
`endif
    end else begin
      gpi_s1_q   <= i_gpi;
      gpi_s2_q   <= gpi_s1_q;
      rvalid_q   <= 1'b0;
      rd_split_q <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      // Second half: bus inputs are ignored, the access is already committed.
      if (in_split) begin
        state_q    <= IDLE;
        buf_q      <= dmem_q;
        rvalid_q   <= read_q;
        rd_split_q <= read_q;
      end else
`else
      misalign_q <= 1'b0;
`endif
      if (accept) begin
        f3_q  <= bus.funct3;
        off_q <= bus.addr[1:0];
        io_q  <= is_gpo ? gpo_rd : gpi_s2_q;
        if (is_dmem)              src_q <= mis_drop ? SrcNone : SrcDmem;
        else if (is_gpo | is_gpi) src_q <= SrcReg;
        else                      src_q <= SrcNone;
`ifdef LSU_MISALIGN_SPLIT_EN
        rvalid_q <= bus.read & ~mis_hit;
        if (mis_hit) begin
          state_q <= SPLIT;
          word1_q <= bus.addr[AW+1:2] + 1'b1;
          wdata_q <= bus.wdata;
          read_q  <= bus.read;
          write_q <= bus.write;
        end
`else
        rvalid_q   <= bus.read;
        misalign_q <= mis_hit;
`endif
        if (bus.write && is_gpo) begin
          for (int k = 0; k < NUM_GPO; k++) begin
            for (int b = 0; b < 4; b++) begin
              if (gpo_off == 20'(k) && g_be[b]) gpo_q[k][8*b +: 8] <= g_data[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Load return path: word0 sits in buf_q while word1 arrives on dmem_q.
  always_comb begin
    case (src_q)
      SrcDmem: raw = dmem_q;
      SrcReg:  raw = io_q;
      default: raw = '0;
    endcase
    r64        = rd_split_q ? {dmem_q, buf_q} : {32'd0, raw};
    sh         = r64[{off_q, 3'b000} +: 32];
    bus.rdata  = rvalid_q ? lsu_extend(sh, f3_q) : '0;
    bus.rvalid = rvalid_q;
  end
endmodule
